// File: rtl/sel_frame_mux_pkg.sv
// Shared types and helpers for the selector-driven frame multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sel_frame_mux_pkg;

  // Largest channel count the selector path is sized for.
  localparam int MAX_INPUTS = 16;

  // Frame FSM: IDLE waits for a selector, ACTIVE forwards one locked frame.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Selector width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_reg.sv
// Single-entry output register with a valid/ready handshake.
// Latency: an accepted input beat is presented on out_dat one cycle later.
// Backpressure: in_rdy = !out_vld || out_rdy, so draining and reloading share a cycle.
module hs_reg #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_vld,
  input  logic             out_rdy
);

  // The slot is free when empty or when its current beat leaves this cycle.
  assign in_rdy = !out_vld || out_rdy;

  // Load a new beat, drop a drained one, or hold a stalled one unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_dat <= in_dat;
      end
    end
  end

endmodule

// File: rtl/sel_frame_mux.sv
// Frame multiplexer: a selector locks one input channel for a whole frame, ended by in_last.
// Latency: one cycle from an accepted input beat to out_vld; err follows a bad selector by one cycle.
// Backpressure: only the locked channel sees ready, and only when the output slot is free; others stall.
module sel_frame_mux
  import sel_frame_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS     = 3,   // legal range 2..MAX_INPUTS
  parameter int SEL_WIDTH  = sel_width(INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [INPUTS-1:0]            in_last,
  input  logic [INPUTS-1:0]            in_vld,
  output logic [INPUTS-1:0]            in_rd,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         sel_vld,
  output logic                         sel_rd,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         out_vld,
  input  logic                         out_rd,
  output logic                         err
);

  // Channel count widened by one bit so "sel < INPUTS" is exact even when
  // INPUTS is a power of two and every selector code is legal.
  localparam logic [SEL_WIDTH:0] NUM_CH = (SEL_WIDTH + 1)'(INPUTS);

  state_t                state;
  state_t                state_nxt;
  logic [SEL_WIDTH-1:0]  lock_idx;
  logic [SEL_WIDTH-1:0]  lock_idx_nxt;
  logic                  err_nxt;

  logic                  sel_ok;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic                  cur_last;
  logic                  cur_vld;
  logic                  beat_vld;
  logic                  hs_in_rdy;
  logic [DATA_WIDTH:0]   hs_out_dat;

  assign sel_ok = ({1'b0, sel} < NUM_CH);

  // Pick payload, last flag and valid of the locked channel.
  always_comb begin
    cur_dat  = '0;
    cur_last = 1'b0;
    cur_vld  = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (lock_idx == SEL_WIDTH'(i)) begin
        cur_dat  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        cur_last = in_last[i];
        cur_vld  = in_vld[i];
      end
    end
  end

  // Ready goes only to the locked channel while a frame is active; the rest stall.
  always_comb begin
    in_rd = '0;
    for (int i = 0; i < INPUTS; i++) begin
      in_rd[i] = (state == ACTIVE) && (lock_idx == SEL_WIDTH'(i)) && hs_in_rdy;
    end
  end

  // Next-state, lock capture, selector ready and error decode.
  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    err_nxt      = 1'b0;
    sel_rd       = 1'b0;
    beat_vld     = 1'b0;
    case (state)
      IDLE: begin
        sel_rd = 1'b1;
        if (sel_vld) begin
          if (sel_ok) begin
            lock_idx_nxt = sel;
            state_nxt    = ACTIVE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // Selector changes are ignored here; the frame ends on its last beat,
        // which still drains through the output register after we leave.
        beat_vld = cur_vld;
        if (cur_vld && hs_in_rdy && cur_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, locked channel and registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_idx <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_idx_nxt;
      err      <= err_nxt;
    end
  end

  hs_reg #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .in_dat  ({cur_last, cur_dat}),
    .in_vld  (beat_vld),
    .in_rdy  (hs_in_rdy),
    .out_dat (hs_out_dat),
    .out_vld (out_vld),
    .out_rdy (out_rd)
  );

  assign out_last = hs_out_dat[DATA_WIDTH];
  assign out_data = hs_out_dat[DATA_WIDTH-1:0];

endmodule
